generation_controller: RTL

Sequencing FSM for the grid state register: drives its `write_enable` and `load_run` select so the register is loaded from the external word, then advanced one Game-of-Life generation at a time from the grid calculator. Supports a programmable generation count, a settle delay per generation for a pipelined calculator, and an early halt. Sits beside the grid state register and grid calculator, under the top-level user interface.

---
 rtl/generation_controller_if.sv | 31 +++
 rtl/generation_controller.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/generation_controller_if.sv
// Signal bundle between the generation controller and the surrounding
// grid logic / user interface. The master side issues load/run/halt
// requests and supplies the grid words; the slave side (the controller)
// returns the register controls and run status.
interface generation_controller_if #(
  parameter int DATA_SIZE = 64,
  parameter int GEN_WIDTH = 16
);
  logic                 load_req;
  logic                 start;
  logic                 halt;
  logic [GEN_WIDTH-1:0] run_gens;
  logic [DATA_SIZE-1:0] grid_in;
  logic [DATA_SIZE-1:0] mem_out;
  logic                 write_enable;
  logic                 load_run;
  logic                 busy;
  logic                 done;
  logic [GEN_WIDTH-1:0] gen_count;
  logic                 stable;

  modport master (
    output load_req, start, halt, run_gens, grid_in, mem_out,
    input  write_enable, load_run, busy, done, gen_count, stable
  );

  modport slave (
    input  load_req, start, halt, run_gens, grid_in, mem_out,
    output write_enable, load_run, busy, done, gen_count, stable
  );
endinterface

// File: rtl/generation_controller.sv
// Sequencing FSM for the Game-of-Life grid state register.
// Loads the register from the external word, then advances it one
// generation per commit from the grid calculator, waiting CALC_LATENCY
// settle cycles before each commit. Runs stop when the programmed count
// is exhausted, on halt, or (optionally) when a still life is seen.
// Optional feature macro: STILL_LIFE_DETECT_EN enables the grid_in ==
// mem_out comparator that ends a run early and sets the sticky stable flag.
module generation_controller #(
  parameter int DATA_SIZE    = 64,
  parameter int GEN_WIDTH    = 16,
  parameter int CALC_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  generation_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Settle counter only needs to hold CALC_LATENCY; keep at least one bit
  // so the zero-latency build still has a legal vector.
  localparam int CW = (CALC_LATENCY < 2) ? 1 : $clog2(CALC_LATENCY + 1);
  localparam logic [CW-1:0] SETTLE_INIT = CW'(CALC_LATENCY);
  // With no calculator latency a generation is a bare commit cycle.
  localparam state_t RUN_ENTRY = (CALC_LATENCY == 0) ? COMMIT : SETTLE;

  state_t               state_reg, state_next;
  logic [CW-1:0]        settle_reg, settle_next;
  logic [GEN_WIDTH-1:0] remaining_reg, remaining_next;
  logic [GEN_WIDTH-1:0] gen_count_reg, gen_count_next;
  logic                 stable_reg, stable_next;

  logic [DATA_SIZE-1:0] next_word;
  logic [DATA_SIZE-1:0] cur_word;

  assign next_word = bus.grid_in;
  assign cur_word  = bus.mem_out;

`ifdef STILL_LIFE_DETECT_EN
  logic same_word;
  // A generation that reproduces the current grid is a still life.
  assign same_word = (next_word == cur_word);
`else
  logic unused_words;
  // Grid words are only consumed by the still-life comparator.
  assign unused_words = ^{next_word, cur_word};
`endif

  // State and run counters; reset abandons any run without a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      settle_reg    <= '0;
      remaining_reg <= '0;
      gen_count_reg <= '0;
      stable_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      settle_reg    <= settle_next;
      remaining_reg <= remaining_next;
      gen_count_reg <= gen_count_next;
      stable_reg    <= stable_next;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_next     = state_reg;
    settle_next    = settle_reg;
    remaining_next = remaining_reg;
    gen_count_next = gen_count_reg;
    stable_next    = stable_reg;

    case (state_reg)
      IDLE: begin
        // Load wins over a simultaneous start; the start is simply dropped.
        if (bus.load_req) begin
          state_next = LOAD;
        end else if (bus.start) begin
          stable_next = 1'b0;
          if (bus.run_gens == '0) begin
            state_next = DONE;
          end else begin
            remaining_next = bus.run_gens;
            settle_next    = SETTLE_INIT;
            state_next     = RUN_ENTRY;
          end
        end
      end

      LOAD: begin
        gen_count_next = '0;
        stable_next    = 1'b0;
        state_next     = IDLE;
      end

      SETTLE: begin
        if (bus.halt) begin
          state_next = DONE;
        end else if (settle_reg <= CW'(1)) begin
          settle_next = '0;
          state_next  = COMMIT;
        end else begin
          settle_next = settle_reg - CW'(1);
        end
      end

      COMMIT: begin
        // The write happens this cycle whatever comes next.
        gen_count_next = gen_count_reg + GEN_WIDTH'(1);
        remaining_next = remaining_reg - GEN_WIDTH'(1);
        if ((remaining_reg == GEN_WIDTH'(1)) || bus.halt) begin
          state_next = DONE;
        end else begin
          settle_next = SETTLE_INIT;
          state_next  = RUN_ENTRY;
        end
`ifdef STILL_LIFE_DETECT_EN
        if (same_word) begin
          stable_next = 1'b1;
          state_next  = DONE;
        end
`endif
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the registered state and counters.
  assign bus.write_enable = (state_reg == LOAD) || (state_reg == COMMIT);
  assign bus.load_run     = (state_reg == SETTLE) || (state_reg == COMMIT) ||
                            (state_reg == DONE);
  assign bus.busy         = (state_reg != IDLE);
  assign bus.done         = (state_reg == DONE);
  assign bus.gen_count    = gen_count_reg;
  assign bus.stable       = stable_reg;

endmodule
